// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation engine.
// Holds the FSM state encoding, default widths and the fixed latency formula.
package rsa_pkg;

  localparam int RSA_W     = 26;
  localparam int RSA_EXP_W = 26;

  typedef enum logic [2:0] {IDLE, LOAD, MUL, SQR, FIN} state_t;

  // Accept edge to done cycle: one load cycle, 2*EXP_W modmuls of W+1 cycles, one finish cycle.
  function automatic int LAT(input int w, input int exp_w);
    return 2 + 2 * exp_w * (w + 1);
  endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add (Blakley) modular multiplier: p = a*b mod n, requires a,b < n.
// start cycle captures operands, W iteration cycles follow, done pulses W+1 cycles after start.
module rsa_modmul #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         done,
  output logic [W-1:0] p
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  a_reg, b_reg, n_reg;
  logic [W:0]    acc_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;

  logic [W:0] n_ext, dbl, red1, add, acc_next;

  // acc < n < 2^W, so the W+1-bit shift never loses a set bit.
  always_comb begin
    n_ext    = {1'b0, n_reg};
    dbl      = acc_reg << 1;
    red1     = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
    add      = a_reg[W-1] ? (red1 + {1'b0, b_reg}) : red1;
    acc_next = (add >= n_ext) ? (add - n_ext) : add;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      n_reg    <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done     <= 1'b0;
      p        <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_reg    <= a;
        b_reg    <= b;
        n_reg    <= n;
        acc_reg  <= '0;
        cnt_reg  <= '0;
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        acc_reg <= acc_next;
        a_reg   <= a_reg << 1;
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == CW'(W - 1)) begin
          busy_reg <= 1'b0;
          done     <= 1'b1;
          p        <= acc_next[W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/rsa_modexp_engine.sv
// Constant-time right-to-left square-and-multiply: result = msg^exp mod modn.
// Optional operand check enabled by defining RSA_MOD_CHECK_EN.
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int W     = RSA_W,
  parameter int EXP_W = RSA_EXP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     msg,
  input  logic [EXP_W-1:0] exp,
  input  logic [W-1:0]     modn,
  output logic             ready,
  output logic             done,
  output logic [W-1:0]     result,
  output logic             err
);

  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  state_t           state_reg;
  logic [W-1:0]     modn_reg, r_reg, base_reg;
  logic [EXP_W-1:0] exp_reg;
  logic [IW-1:0]    i_reg;
  logic             last_bit, skip;
  logic             mm_start, mm_done;
  logic [W-1:0]     mm_a, mm_b, mm_p;

`ifdef RSA_MOD_CHECK_EN
  logic bad_reg, err_reg;
  assign skip = bad_reg;
  assign err  = err_reg;
`else
  assign skip = 1'b0;
  assign err  = 1'b0;
`endif

  assign last_bit = (i_reg == IW'(EXP_W - 1));

  // Each modmul is launched in the cycle the previous one completes, so the new base
  // from a finishing square is forwarded straight from the multiplier output.
  assign mm_a     = (state_reg == MUL) ? base_reg : r_reg;
  assign mm_b     = (state_reg == SQR) ? mm_p : base_reg;
  assign mm_start = ((state_reg == LOAD) && !skip) ||
                    (mm_done && ((state_reg == MUL) || ((state_reg == SQR) && !last_bit)));

  rsa_modmul #(.W(W)) u_modmul (
    .clk   (clk),
    .rst   (rst),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .n     (modn_reg),
    .done  (mm_done),
    .p     (mm_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      result    <= '0;
      modn_reg  <= '0;
      r_reg     <= '0;
      base_reg  <= '0;
      exp_reg   <= '0;
      i_reg     <= '0;
`ifdef RSA_MOD_CHECK_EN
      bad_reg   <= 1'b0;
      err_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            modn_reg  <= modn;
            exp_reg   <= exp;
            base_reg  <= msg;
            r_reg     <= (modn > W'(1)) ? W'(1) : '0;
            i_reg     <= '0;
            ready     <= 1'b0;
            state_reg <= LOAD;
`ifdef RSA_MOD_CHECK_EN
            bad_reg   <= (modn < W'(2)) || (msg >= modn);
`endif
          end
        end
        LOAD: begin
          if (skip) begin
            state_reg <= FIN;
            done      <= 1'b1;
            result    <= '0;
`ifdef RSA_MOD_CHECK_EN
            err_reg   <= 1'b1;
`endif
          end else begin
            state_reg <= MUL;
          end
        end
        MUL: begin
          if (mm_done) begin
            if (exp_reg[0]) r_reg <= mm_p;
            exp_reg   <= exp_reg >> 1;
            state_reg <= SQR;
          end
        end
        SQR: begin
          if (mm_done) begin
            base_reg <= mm_p;
            if (last_bit) begin
              state_reg <= FIN;
              done      <= 1'b1;
              result    <= r_reg;
`ifdef RSA_MOD_CHECK_EN
              err_reg   <= 1'b0;
`endif
            end else begin
              i_reg     <= i_reg + 1'b1;
              state_reg <= MUL;
            end
          end
        end
        FIN: begin
          done      <= 1'b0;
          ready     <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
